rom_port_arbiter: RTL

// - Shares one SDRAM ROM read port between NUM read-only cache instances (CPU, sprite, tile, sound).
// - Each client uses the cache ROM handshake: level rom_req plus rom_addr, held until a one-cycle rom_valid.
// - Round-robin grant; one outstanding SDRAM read at a time.
// - Sits between the caches and the SDRAM controller read channel.

---
 rtl/rom_port_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/rom_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rom_port_arbiter
// Purpose  : Round-robin arbiter sharing one SDRAM ROM read port between NUM
//            read-only cache clients. Clients use a level request held until
//            a one-cycle valid strobe. Only one SDRAM read is in flight at a time.
// Options  : ROM_ARB_TIMEOUT_EN - enables the WAIT-state watchdog and the
//            sticky err flag. When it is undefined, err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module rom_port_arbiter #(
    parameter int NUM     = 4,
    parameter int AW      = 23,
    parameter int DW      = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM-1:0]    cli_req,
    input  logic [NUM*AW-1:0] cli_addr,
    output logic [NUM-1:0]    cli_valid,
    output logic [DW-1:0]     cli_data,
    output logic              sdram_req,
    output logic [AW-1:0]     sdram_addr,
    input  logic              sdram_valid,
    input  logic [DW-1:0]     sdram_data,
    output logic [2:0]        grant,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [2:0]      r_ptr;
    logic [2:0]      r_grant;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_data;
    logic [NUM-1:0]  r_valid;
    logic            r_req;
    logic            r_busy;

    logic            w_any;
    logic [2:0]      w_sel;
    logic [AW-1:0]   w_addr;
    logic [NUM-1:0]  w_onehot;

`ifdef ROM_ARB_TIMEOUT_EN
    logic [15:0]     r_cnt;
    logic            r_err;
`else
    // TIMEOUT only matters when the watchdog is built in.
    logic            w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
`endif

    // Round-robin pick: first requesting client after the last grant, wrapping.
    always_comb begin
        w_any  = 1'b0;
        w_sel  = 3'd0;
        w_addr = '0;
        for (int i = 1; i <= NUM; i++) begin
            for (int k = 0; k < NUM; k++) begin
                if (!w_any && (k == ((int'(r_ptr) + i) % NUM)) && cli_req[k]) begin
                    w_any  = 1'b1;
                    w_sel  = 3'(k);
                    w_addr = cli_addr[k*AW +: AW];
                end
            end
        end
    end

    // One-hot decode of the granted client, used for the done strobe.
    always_comb begin
        w_onehot = '0;
        for (int k = 0; k < NUM; k++) begin
            w_onehot[k] = (r_grant == 3'(k));
        end
    end

    // Arbiter FSM: IDLE picks a client, WAIT holds the SDRAM read, DONE gives
    // the client one cycle to drop its request before re-arbitration.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_ptr   <= 3'(NUM - 1);
            r_grant <= 3'd0;
            r_addr  <= '0;
            r_data  <= '0;
            r_valid <= '0;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
`ifdef ROM_ARB_TIMEOUT_EN
            r_cnt   <= 16'd0;
            r_err   <= 1'b0;
`endif
        end else begin
            r_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    // sdram_valid is deliberately ignored here so stale returns vanish.
                    if (w_any) begin
                        r_grant <= w_sel;
                        r_ptr   <= w_sel;
                        r_addr  <= w_addr;
                        r_req   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_WAIT;
`ifdef ROM_ARB_TIMEOUT_EN
                        r_cnt   <= 16'd0;
`endif
                    end
                end
                S_WAIT: begin
                    // A real return always beats the watchdog on the same cycle.
                    if (sdram_valid) begin
                        r_data  <= sdram_data;
                        r_valid <= w_onehot;
                        r_req   <= 1'b0;
                        r_state <= S_DONE;
                    end
`ifdef ROM_ARB_TIMEOUT_EN
                    else if (r_cnt == 16'(TIMEOUT - 1)) begin
                        r_data  <= '1;
                        r_valid <= w_onehot;
                        r_req   <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt   <= r_cnt + 16'd1;
                    end
`endif
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cli_valid  = r_valid;
    assign cli_data   = r_data;
    assign sdram_req  = r_req;
    assign sdram_addr = r_addr;
    assign grant      = r_grant;
    assign busy       = r_busy;
`ifdef ROM_ARB_TIMEOUT_EN
    assign err        = r_err;
`else
    assign err        = 1'b0;
`endif

endmodule
`default_nettype wire
